alu_reservation_station: RTL and testbench
==========================================

Name: alu_reservation_station

Overview:
Reservation station directly upstream of the ALU.
- Accepts dispatched ALU ops whose operands are values or pending ROB tags.
- Snoops the CDB to capture pending operands, issues ready ops to the ALU one at a time, and collects the ALU result.
- Presents the result to the CDB arbiter and frees the entry on grant.

Parameters:
NUM_ENTRIES, 4, station depth (2..8)
ROB_IDX_W, 3, ROB tag width
DATA_W, 32, operand/result width

Ports:
clk_in  in  1  clock
rst_in  in  1  reset; asynchronous, active-high
flush_in  in  1  synchronous squash of all entries
dispatch_valid_in  in  1  op offered
dispatch_ready_out  out  1  free entry exists
dispatch_func_in  in  4  AluFunc code
dispatch_rob_idx_in  in  ROB_IDX_W  destination tag
dispatch_v1_in / dispatch_v2_in  in  DATA_W  operand values
dispatch_q1_wait_in / dispatch_q2_wait_in  in  1  1 = operand pending on tag
dispatch_q1_in / dispatch_q2_in  in  ROB_IDX_W  pending tag
cdb_valid_in  in  1  CDB broadcast valid
cdb_rob_idx_in  in  ROB_IDX_W  broadcast tag
cdb_data_in  in  DATA_W  broadcast value
alu_valid_out  out  1  start pulse to ALU
alu_func_out  out  4  to ALU
alu_rob_idx_out  out  ROB_IDX_W  to ALU
alu_rval1_out / alu_rval2_out  out  DATA_W  operands, held stable through WAIT
alu_ready_in  in  1  ALU idle
alu_valid_in  in  1  ALU result valid, level until read
alu_data_in  in  DATA_W  ALU result
alu_read_out  out  1  result consumed
result_valid_out  out  1  CDB request
result_rob_idx_out  out  ROB_IDX_W  CDB tag
result_data_out  out  DATA_W  CDB value
result_grant_in  in  1  CDB arbiter grant

Behaviour:
- Reset (async, rst_in=1): all entries invalid, FSM IDLE. Outputs: alu_valid_out=0, alu_read_out=0, result_valid_out=0, all data/tag outputs=0, dispatch_ready_out=1.
- Dispatch: dispatch_ready_out = any entry invalid (combinational from state). Accepted when valid&&ready; written to the lowest free index.
- Same-cycle bypass: if a dispatched operand waits on tag T while cdb_valid_in && cdb_rob_idx_in==T, the entry stores cdb_data_in as a resolved value.
- CDB snoop: each cycle, every valid entry with a pending tag matching the broadcast captures cdb_data_in and clears its wait bit.
- Entry ready = valid && both operands resolved. Pick = lowest-index ready entry not already issued.
- FSM states: IDLE, WAIT, BCAST, DRAIN.
- IDLE: if a ready entry exists && alu_ready_in && !flush_in:
  - alu_valid_out=1 for exactly one cycle;
  - latch entry index; drive that entry's func/tag/operands;
  - -> WAIT.
- WAIT: operands held constant, since the ALU output is combinational on them. When alu_valid_in:
  - alu_read_out=1 (combinational, same cycle);
  - latch alu_data_in and tag into the result registers;
  - -> BCAST.
- BCAST: result_valid_out=1, holding value/tag until result_grant_in. On grant: free entry, result_valid_out=0, -> IDLE. No new issue during BCAST, so at most one op is in flight.
- Own result returns to waiting entries only via the cdb_* inputs; there is no internal shortcut.
- Latency: dispatch of an all-resolved op into an empty station -> alu_valid_out the next cycle. ALU result -> result_valid_out the next cycle.
- flush_in (synchronous, priority over dispatch/snoop):
  - all entries invalid; result_valid_out=0.
  - From WAIT -> DRAIN. DRAIN waits for alu_valid_in, pulses alu_read_out, discards the data, -> IDLE.
  - From IDLE/BCAST -> IDLE.
  - Flush during DRAIN stays in DRAIN.
- Full: dispatch_ready_out=0. A dispatch attempted while full is ignored.
- Simultaneous grant and dispatch with the station full: the freed slot is visible only next cycle.
- Reset mid-operation clears the state. The ALU is reset by the same rst_in, so no drain is needed.

Decomposition:
- types.svh (shared): existing AluFunc enum.
- Add rs_entry_t struct: valid, issued, func, rob_idx, v1, v2, q1_wait, q2_wait, q1, q2.
- Add rs_state_t enum: IDLE/WAIT/BCAST/DRAIN.
- One sub-module: rs_priority_pick, a parameterised lowest-set-bit one-hot/index encoder with an any-set flag. Used for both free-slot allocation and issue selection.

Test Plan:
- Dispatch Add, v1=5, v2=7, both resolved, ALU model 15-cycle stall:
  - alu_valid_out one cycle later;
  - result_valid_out with data 12 and tag unchanged;
  - grant frees the entry.
- Dispatch Sub, q1 waiting on tag 3, v2=1:
  - no issue until CDB broadcasts tag 3, data 10;
  - issue next cycle, result 9.
- Dispatch with q1 waiting on tag 2 in the same cycle CDB broadcasts tag 2, data 0xFFFF_FFFF:
  - bypass captured;
  - Xor with v2=0x0F gives 0xFFFF_FFF0.
- Fill all 4 entries:
  - dispatch_ready_out=0, extra dispatch dropped;
  - entries issue in index order 0,1,2,3;
  - each is freed only on result_grant_in, even when grant is held low for 5 cycles.
- Flush in WAIT:
  - DRAIN pulses alu_read_out when the ALU completes;
  - result_valid_out stays 0; station empty; next dispatch issues normally.
- Assert rst_in asynchronously mid-BCAST: all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/alu_reservation_station_pkg.sv
// Shared types for the ALU reservation station: ALU function codes,
// the station FSM encoding and common widths.
package alu_reservation_station_pkg;

    localparam int FUNC_W = 4;

    // ALU function codes understood by the downstream ALU.
    typedef enum logic [FUNC_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_func_e;

    // Issue/completion FSM: at most one op is ever in flight in the ALU.
    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_WAIT  = 2'd1,
        RS_BCAST = 2'd2,
        RS_DRAIN = 2'd3
    } rs_state_t;

endpackage

// File: rtl/alu_reservation_station_if.sv
// Bundle of dispatch, CDB snoop, ALU and CDB-request signals around the
// reservation station. "slave" is the station side, "master" the pipeline.
interface alu_reservation_station_if
    import alu_reservation_station_pkg::*;
#(
    parameter int ROB_IDX_W = 3,
    parameter int DATA_W    = 32
) ();

    logic                 flush_in;

    logic                 dispatch_valid_in;
    logic                 dispatch_ready_out;
    logic [FUNC_W-1:0]    dispatch_func_in;
    logic [ROB_IDX_W-1:0] dispatch_rob_idx_in;
    logic [DATA_W-1:0]    dispatch_v1_in;
    logic [DATA_W-1:0]    dispatch_v2_in;
    logic                 dispatch_q1_wait_in;
    logic                 dispatch_q2_wait_in;
    logic [ROB_IDX_W-1:0] dispatch_q1_in;
    logic [ROB_IDX_W-1:0] dispatch_q2_in;

    logic                 cdb_valid_in;
    logic [ROB_IDX_W-1:0] cdb_rob_idx_in;
    logic [DATA_W-1:0]    cdb_data_in;

    logic                 alu_valid_out;
    logic [FUNC_W-1:0]    alu_func_out;
    logic [ROB_IDX_W-1:0] alu_rob_idx_out;
    logic [DATA_W-1:0]    alu_rval1_out;
    logic [DATA_W-1:0]    alu_rval2_out;
    logic                 alu_ready_in;
    logic                 alu_valid_in;
    logic [DATA_W-1:0]    alu_data_in;
    logic                 alu_read_out;

    logic                 result_valid_out;
    logic [ROB_IDX_W-1:0] result_rob_idx_out;
    logic [DATA_W-1:0]    result_data_out;
    logic                 result_grant_in;

    modport slave (
        input  flush_in,
        input  dispatch_valid_in, dispatch_func_in, dispatch_rob_idx_in,
        input  dispatch_v1_in, dispatch_v2_in,
        input  dispatch_q1_wait_in, dispatch_q2_wait_in, dispatch_q1_in, dispatch_q2_in,
        output dispatch_ready_out,
        input  cdb_valid_in, cdb_rob_idx_in, cdb_data_in,
        output alu_valid_out, alu_func_out, alu_rob_idx_out, alu_rval1_out, alu_rval2_out,
        input  alu_ready_in, alu_valid_in, alu_data_in,
        output alu_read_out,
        output result_valid_out, result_rob_idx_out, result_data_out,
        input  result_grant_in
    );

    modport master (
        output flush_in,
        output dispatch_valid_in, dispatch_func_in, dispatch_rob_idx_in,
        output dispatch_v1_in, dispatch_v2_in,
        output dispatch_q1_wait_in, dispatch_q2_wait_in, dispatch_q1_in, dispatch_q2_in,
        input  dispatch_ready_out,
        output cdb_valid_in, cdb_rob_idx_in, cdb_data_in,
        input  alu_valid_out, alu_func_out, alu_rob_idx_out, alu_rval1_out, alu_rval2_out,
        output alu_ready_in, alu_valid_in, alu_data_in,
        input  alu_read_out,
        input  result_valid_out, result_rob_idx_out, result_data_out,
        output result_grant_in
    );

endinterface

// File: rtl/alu_reservation_station_priority_pick.sv
// Lowest-set-bit encoder: one-hot and binary index of the lowest request,
// plus an any-set flag. Used for free-slot allocation and issue selection.
module alu_reservation_station_priority_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan from the top down so the lowest set request wins last.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Reservation station in front of a single ALU: holds dispatched ops until
// their operands arrive on the CDB, issues one at a time, and requests the
// CDB for the result. An entry is freed only when its result is granted.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int ROB_IDX_W   = 3,
    parameter int DATA_W      = 32
) (
    input logic                      clk_in,
    input logic                      rst_in,
    alu_reservation_station_if.slave bus
);

    localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef struct packed {
        logic                 valid;
        logic                 issued;
        logic [FUNC_W-1:0]    func;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    v1;
        logic [DATA_W-1:0]    v2;
        logic                 q1_wait;
        logic                 q2_wait;
        logic [ROB_IDX_W-1:0] q1;
        logic [ROB_IDX_W-1:0] q2;
    } rs_entry_t;

    rs_entry_t            r_entries [NUM_ENTRIES];
    rs_state_t            r_state;
    rs_state_t            w_next_state;
    logic [IDX_W-1:0]     r_issue_idx;

    // Copy of the issued op; keeps ALU operands stable even if the entry is flushed.
    logic [FUNC_W-1:0]    r_alu_func;
    logic [ROB_IDX_W-1:0] r_alu_rob;
    logic [DATA_W-1:0]    r_alu_v1;
    logic [DATA_W-1:0]    r_alu_v2;

    logic [ROB_IDX_W-1:0] r_res_rob;
    logic [DATA_W-1:0]    r_res_data;

    logic [NUM_ENTRIES-1:0] w_free_req;
    logic [NUM_ENTRIES-1:0] w_ready_req;
    logic [NUM_ENTRIES-1:0] w_free_onehot;
    logic [NUM_ENTRIES-1:0] w_ready_onehot;
    logic [IDX_W-1:0]       w_free_idx;
    logic [IDX_W-1:0]       w_ready_idx;
    logic                   w_free_any;
    logic                   w_ready_any;

    logic                   w_dispatch_fire;
    logic                   w_issue;
    logic                   w_result_take;
    logic                   w_grant_free;
    logic                   w_q1_hit;
    logic                   w_q2_hit;
    rs_entry_t              w_new_entry;
    rs_entry_t              w_pick;

    // Per-entry free and ready-to-issue request vectors.
    always_comb begin
        w_free_req  = '0;
        w_ready_req = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_free_req[i]  = !r_entries[i].valid;
            w_ready_req[i] = r_entries[i].valid && !r_entries[i].issued &&
                             !r_entries[i].q1_wait && !r_entries[i].q2_wait;
        end
    end

    alu_reservation_station_priority_pick #(
        .N     (NUM_ENTRIES),
        .IDX_W (IDX_W)
    ) u_free_pick (
        .i_req    (w_free_req),
        .o_onehot (w_free_onehot),
        .o_idx    (w_free_idx),
        .o_any    (w_free_any)
    );

    alu_reservation_station_priority_pick #(
        .N     (NUM_ENTRIES),
        .IDX_W (IDX_W)
    ) u_issue_pick (
        .i_req    (w_ready_req),
        .o_onehot (w_ready_onehot),
        .o_idx    (w_ready_idx),
        .o_any    (w_ready_any)
    );

    assign w_pick          = r_entries[w_ready_idx];
    assign w_dispatch_fire = bus.dispatch_valid_in && w_free_any && !bus.flush_in;
    assign w_issue         = (r_state == RS_IDLE) && w_ready_any && bus.alu_ready_in && !bus.flush_in;
    assign w_result_take   = (r_state == RS_WAIT) && bus.alu_valid_in && !bus.flush_in;
    assign w_grant_free    = (r_state == RS_BCAST) && bus.result_grant_in && !bus.flush_in;

    // Build the incoming entry, capturing a same-cycle CDB broadcast of a pending tag.
    always_comb begin
        w_q1_hit = bus.dispatch_q1_wait_in && bus.cdb_valid_in &&
                   (bus.cdb_rob_idx_in == bus.dispatch_q1_in);
        w_q2_hit = bus.dispatch_q2_wait_in && bus.cdb_valid_in &&
                   (bus.cdb_rob_idx_in == bus.dispatch_q2_in);
        w_new_entry         = '0;
        w_new_entry.valid   = 1'b1;
        w_new_entry.issued  = 1'b0;
        w_new_entry.func    = bus.dispatch_func_in;
        w_new_entry.rob_idx = bus.dispatch_rob_idx_in;
        w_new_entry.v1      = w_q1_hit ? bus.cdb_data_in : bus.dispatch_v1_in;
        w_new_entry.v2      = w_q2_hit ? bus.cdb_data_in : bus.dispatch_v2_in;
        w_new_entry.q1_wait = bus.dispatch_q1_wait_in && !w_q1_hit;
        w_new_entry.q2_wait = bus.dispatch_q2_wait_in && !w_q2_hit;
        w_new_entry.q1      = bus.dispatch_q1_in;
        w_new_entry.q2      = bus.dispatch_q2_in;
    end

    // Entry array: flush, dispatch write, CDB snoop, issue mark and grant free.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            // NOTE: the whole (small) entry array is reset so no stale valid/wait bits survive reset.
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (bus.flush_in) begin
                    r_entries[i].valid  <= 1'b0;
                    r_entries[i].issued <= 1'b0;
                end else if (w_dispatch_fire && w_free_onehot[i]) begin
                    // NOTE: non-blocking so every entry sees this cycle's state regardless of loop order.
                    r_entries[i] <= w_new_entry;
                end else if (r_entries[i].valid) begin
                    if (bus.cdb_valid_in && r_entries[i].q1_wait &&
                        (r_entries[i].q1 == bus.cdb_rob_idx_in)) begin
                        r_entries[i].v1      <= bus.cdb_data_in;
                        r_entries[i].q1_wait <= 1'b0;
                    end
                    if (bus.cdb_valid_in && r_entries[i].q2_wait &&
                        (r_entries[i].q2 == bus.cdb_rob_idx_in)) begin
                        r_entries[i].v2      <= bus.cdb_data_in;
                        r_entries[i].q2_wait <= 1'b0;
                    end
                    if (w_issue && w_ready_onehot[i]) begin
                        r_entries[i].issued <= 1'b1;
                    end
                    if (w_grant_free && (r_issue_idx == IDX_W'(i))) begin
                        r_entries[i].valid  <= 1'b0;
                        r_entries[i].issued <= 1'b0;
                    end
                end
            end
        end
    end

    // Latch the issued op and the returned result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_issue_idx <= '0;
            r_alu_func  <= '0;
            r_alu_rob   <= '0;
            r_alu_v1    <= '0;
            r_alu_v2    <= '0;
            r_res_rob   <= '0;
            r_res_data  <= '0;
        end else begin
            if (w_issue) begin
                r_issue_idx <= w_ready_idx;
                r_alu_func  <= w_pick.func;
                r_alu_rob   <= w_pick.rob_idx;
                r_alu_v1    <= w_pick.v1;
                r_alu_v2    <= w_pick.v2;
            end
            if (w_result_take) begin
                r_res_rob  <= r_alu_rob;
                r_res_data <= bus.alu_data_in;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= RS_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a flush that coincides with the ALU result needs no drain.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RS_IDLE: begin
                if (w_issue) w_next_state = RS_WAIT;
            end
            RS_WAIT: begin
                if (bus.flush_in)          w_next_state = bus.alu_valid_in ? RS_IDLE : RS_DRAIN;
                else if (bus.alu_valid_in) w_next_state = RS_BCAST;
            end
            RS_BCAST: begin
                if (bus.flush_in || bus.result_grant_in) w_next_state = RS_IDLE;
            end
            RS_DRAIN: begin
                if (bus.alu_valid_in) w_next_state = RS_IDLE;
            end
            default: w_next_state = RS_IDLE;
        endcase
    end

    // FSM outputs: issue pulse drives the picked entry, then the latched copy holds.
    always_comb begin
        bus.alu_valid_out   = w_issue;
        bus.alu_read_out    = ((r_state == RS_WAIT) || (r_state == RS_DRAIN)) && bus.alu_valid_in;
        bus.alu_func_out    = '0;
        bus.alu_rob_idx_out = '0;
        bus.alu_rval1_out   = '0;
        bus.alu_rval2_out   = '0;
        if (w_issue) begin
            bus.alu_func_out    = w_pick.func;
            bus.alu_rob_idx_out = w_pick.rob_idx;
            bus.alu_rval1_out   = w_pick.v1;
            bus.alu_rval2_out   = w_pick.v2;
        end else if ((r_state == RS_WAIT) || (r_state == RS_DRAIN)) begin
            bus.alu_func_out    = r_alu_func;
            bus.alu_rob_idx_out = r_alu_rob;
            bus.alu_rval1_out   = r_alu_v1;
            bus.alu_rval2_out   = r_alu_v2;
        end
        bus.result_valid_out   = (r_state == RS_BCAST);
        bus.result_rob_idx_out = r_res_rob;
        bus.result_data_out    = r_res_data;
    end

    assign bus.dispatch_ready_out = w_free_any;

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station with a small stalling ALU model.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk_in = ~clk_in;

    alu_reservation_station_if #(.ROB_IDX_W(3), .DATA_W(32)) bus ();

    alu_reservation_station #(
        .NUM_ENTRIES (4),
        .ROB_IDX_W   (3),
        .DATA_W      (32)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    // ALU reference behaviour (combinational on the presented operands).
    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_SLL:  return a << b[4:0];
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  return {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: return {31'b0, (a < b)};
            default:  return 32'h0;
        endcase
    endfunction

    // ALU model: accepts a start pulse, stalls m_stall cycles, holds result until read.
    int   m_stall = 0;
    int   m_cnt   = 0;
    int   n_issue = 0;
    logic m_busy  = 1'b0;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            m_busy           <= 1'b0;
            m_cnt            <= 0;
            bus.alu_valid_in <= 1'b0;
        end else if (!m_busy) begin
            if (bus.alu_valid_out) begin
                m_busy  <= 1'b1;
                m_cnt   <= m_stall;
                n_issue <= n_issue + 1;
            end
        end else if (!bus.alu_valid_in) begin
            if (m_cnt == 0) bus.alu_valid_in <= 1'b1;
            else            m_cnt <= m_cnt - 1;
        end else if (bus.alu_read_out) begin
            bus.alu_valid_in <= 1'b0;
            m_busy           <= 1'b0;
        end
    end

    assign bus.alu_ready_in = !m_busy;
    assign bus.alu_data_in  = alu_ref(bus.alu_func_out, bus.alu_rval1_out, bus.alu_rval2_out);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic dispatch(input logic [3:0] f, input logic [2:0] tag, input logic [31:0] a,
                            input logic [31:0] b, input logic q1w, input logic [2:0] q1);
        bus.dispatch_valid_in   = 1'b1;
        bus.dispatch_func_in    = f;
        bus.dispatch_rob_idx_in = tag;
        bus.dispatch_v1_in      = a;
        bus.dispatch_v2_in      = b;
        bus.dispatch_q1_wait_in = q1w;
        bus.dispatch_q1_in      = q1;
        tick();
        bus.dispatch_valid_in   = 1'b0;
        bus.dispatch_q1_wait_in = 1'b0;
    endtask

    task automatic wait_alu_done(input string name, input int budget);
        int n = 0;
        while (!bus.alu_valid_in && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(bus.alu_valid_in), 32'd1);
    endtask

    task automatic wait_result(input string name, input int budget);
        int n = 0;
        while (!bus.result_valid_out && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(bus.result_valid_out), 32'd1);
    endtask

    task automatic grant();
        bus.result_grant_in = 1'b1;
        tick();
        bus.result_grant_in = 1'b0;
    endtask

    // From WAIT: ALU completes, result appears next cycle, check it and grant it.
    task automatic finish_op(input string name, input logic [31:0] exp_data, input logic [2:0] exp_tag);
        wait_alu_done({name, "_alu_done"}, 40);
        check({name, "_read"}, 32'(bus.alu_read_out), 32'd1);
        tick();
        check({name, "_res_valid"}, 32'(bus.result_valid_out), 32'd1);
        check({name, "_res_data"}, bus.result_data_out, exp_data);
        check({name, "_res_tag"}, 32'(bus.result_rob_idx_out), 32'(exp_tag));
        grant();
        check({name, "_freed"}, 32'(bus.result_valid_out), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic [3:0]  func;
        logic [2:0]  tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n0;
        vecs[0] = '{"add_wrap", ALU_ADD,  3'd2, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[1] = '{"sub_neg",  ALU_SUB,  3'd3, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
        vecs[2] = '{"and",      ALU_AND,  3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[3] = '{"or",       ALU_OR,   3'd5, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF};
        vecs[4] = '{"xor",      ALU_XOR,  3'd6, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};
        vecs[5] = '{"sll",      ALU_SLL,  3'd7, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
        vecs[6] = '{"sra",      ALU_SRA,  3'd0, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[7] = '{"sltu",     ALU_SLTU, 3'd1, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[8] = '{"slt",      ALU_SLT,  3'd2, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};

        bus.flush_in            = 1'b0;
        bus.dispatch_valid_in   = 1'b0;
        bus.dispatch_func_in    = '0;
        bus.dispatch_rob_idx_in = '0;
        bus.dispatch_v1_in      = '0;
        bus.dispatch_v2_in      = '0;
        bus.dispatch_q1_wait_in = 1'b0;
        bus.dispatch_q2_wait_in = 1'b0;
        bus.dispatch_q1_in      = '0;
        bus.dispatch_q2_in      = '0;
        bus.cdb_valid_in        = 1'b0;
        bus.cdb_rob_idx_in      = '0;
        bus.cdb_data_in         = '0;
        bus.result_grant_in     = 1'b0;

        // Reset values.
        #1;
        check("rst_alu_valid", 32'(bus.alu_valid_out), 32'd0);
        check("rst_alu_read", 32'(bus.alu_read_out), 32'd0);
        check("rst_res_valid", 32'(bus.result_valid_out), 32'd0);
        check("rst_res_data", bus.result_data_out, 32'd0);
        check("rst_ready", 32'(bus.dispatch_ready_out), 32'd1);
        tick();
        tick();
        rst_in = 1'b0;
        tick();

        // Add 5+7 with a 15-cycle ALU stall.
        m_stall = 15;
        dispatch(ALU_ADD, 3'd5, 32'd5, 32'd7, 1'b0, 3'd0);
        check("add_issue_latency", 32'(bus.alu_valid_out), 32'd1);
        check("add_issue_func", 32'(bus.alu_func_out), 32'(ALU_ADD));
        check("add_issue_tag", 32'(bus.alu_rob_idx_out), 32'd5);
        tick();
        check("add_pulse_one_cycle", 32'(bus.alu_valid_out), 32'd0);
        wait_alu_done("add_alu_done", 40);
        check("add_operand_hold", bus.alu_rval1_out, 32'd5);
        check("add_res_not_yet", 32'(bus.result_valid_out), 32'd0);
        tick();
        check("add_res_valid", 32'(bus.result_valid_out), 32'd1);
        check("add_res_data", bus.result_data_out, 32'd12);
        check("add_res_tag", 32'(bus.result_rob_idx_out), 32'd5);
        grant();
        check("add_freed", 32'(bus.result_valid_out), 32'd0);

        // Sub with q1 pending on tag 3, resolved by CDB.
        m_stall = 2;
        n0 = n_issue;
        dispatch(ALU_SUB, 3'd4, 32'h0, 32'd1, 1'b1, 3'd3);
        repeat (3) tick();
        check("sub_no_early_issue", 32'(n_issue - n0), 32'd0);
        bus.cdb_valid_in   = 1'b1;
        bus.cdb_rob_idx_in = 3'd3;
        bus.cdb_data_in    = 32'd10;
        check("sub_not_ready_on_cdb", 32'(bus.alu_valid_out), 32'd0);
        tick();
        bus.cdb_valid_in = 1'b0;
        check("sub_issue_after_cdb", 32'(bus.alu_valid_out), 32'd1);
        check("sub_captured_v1", bus.alu_rval1_out, 32'd10);
        finish_op("sub", 32'd9, 3'd4);

        // Same-cycle CDB bypass at dispatch.
        bus.cdb_valid_in   = 1'b1;
        bus.cdb_rob_idx_in = 3'd2;
        bus.cdb_data_in    = 32'hFFFF_FFFF;
        dispatch(ALU_XOR, 3'd1, 32'h1234, 32'h0F, 1'b1, 3'd2);
        bus.cdb_valid_in = 1'b0;
        check("bypass_issue", 32'(bus.alu_valid_out), 32'd1);
        check("bypass_v1", bus.alu_rval1_out, 32'hFFFF_FFFF);
        finish_op("bypass", 32'hFFFF_FFF0, 3'd1);

        // Table of resolved ops across the function set.
        for (int i = 0; i < 9; i++) begin
            dispatch(vecs[i].func, vecs[i].tag, vecs[i].a, vecs[i].b, 1'b0, 3'd0);
            check({vecs[i].name, "_issue"}, 32'(bus.alu_valid_out), 32'd1);
            check({vecs[i].name, "_func"}, 32'(bus.alu_func_out), 32'(vecs[i].func));
            finish_op(vecs[i].name, vecs[i].exp, vecs[i].tag);
        end

        // Fill all four entries; extra dispatch dropped; index-order issue.
        m_stall = 1;
        n0 = n_issue;
        for (int i = 0; i < 4; i++) begin
            dispatch(ALU_ADD, 3'(i), 32'(i), 32'd100, 1'b0, 3'd0);
        end
        check("full_ready_low", 32'(bus.dispatch_ready_out), 32'd0);
        dispatch(ALU_ADD, 3'd7, 32'd0, 32'd0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            wait_result("full_res_wait", 20);
            repeat (5) tick();
            check("full_grant_hold", 32'(bus.result_valid_out), 32'd1);
            check("full_res_tag", 32'(bus.result_rob_idx_out), 32'(i));
            check("full_res_data", bus.result_data_out, 32'(100 + i));
            if (i == 0) begin
                check("full_still_full", 32'(bus.dispatch_ready_out), 32'd0);
                bus.result_grant_in = 1'b1;
                dispatch(ALU_ADD, 3'd6, 32'd0, 32'd0, 1'b0, 3'd0);
                bus.result_grant_in = 1'b0;
            end else begin
                grant();
            end
        end
        repeat (5) tick();
        check("full_issue_count", 32'(n_issue - n0), 32'd4);
        check("full_empty_ready", 32'(bus.dispatch_ready_out), 32'd1);
        check("full_no_result", 32'(bus.result_valid_out), 32'd0);

        // Flush while the ALU is busy: drain, then normal operation resumes.
        m_stall = 4;
        n0 = n_issue;
        dispatch(ALU_ADD, 3'd2, 32'd3, 32'd4, 1'b0, 3'd0);
        check("flush_op_issue", 32'(bus.alu_valid_out), 32'd1);
        tick();
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        check("flush_res_low", 32'(bus.result_valid_out), 32'd0);
        check("flush_ready", 32'(bus.dispatch_ready_out), 32'd1);
        wait_alu_done("drain_alu_done", 20);
        check("drain_read", 32'(bus.alu_read_out), 32'd1);
        tick();
        check("drain_read_pulse", 32'(bus.alu_read_out), 32'd0);
        check("drain_no_result", 32'(bus.result_valid_out), 32'd0);
        dispatch(ALU_ADD, 3'd3, 32'd20, 32'd22, 1'b0, 3'd0);
        check("post_flush_issue", 32'(bus.alu_valid_out), 32'd1);
        finish_op("post_flush", 32'd42, 3'd3);
        check("flush_issue_count", 32'(n_issue - n0), 32'd2);

        // Asynchronous reset while in BCAST.
        m_stall = 1;
        dispatch(ALU_ADD, 3'd6, 32'd1, 32'd2, 1'b0, 3'd0);
        wait_alu_done("arst_alu_done", 20);
        tick();
        check("arst_pre_bcast", 32'(bus.result_valid_out), 32'd1);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_res_valid", 32'(bus.result_valid_out), 32'd0);
        check("arst_res_data", bus.result_data_out, 32'd0);
        check("arst_res_tag", 32'(bus.result_rob_idx_out), 32'd0);
        check("arst_alu_valid", 32'(bus.alu_valid_out), 32'd0);
        check("arst_alu_read", 32'(bus.alu_read_out), 32'd0);
        check("arst_alu_rval1", bus.alu_rval1_out, 32'd0);
        check("arst_ready", 32'(bus.dispatch_ready_out), 32'd1);
        tick();
        rst_in = 1'b0;
        repeat (2) tick();
        check("arst_stays_idle", 32'(bus.alu_valid_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
